// File: rtl/bi_bus_driver_if.sv
// Handshake and physical-bus bundle for the bus-invert transmit stage.
// The slave modport is the driver's view: it takes raw words in and
// drives the encoded bus out. The master modport is the view of whatever
// surrounds it, which is both the word producer and the bus consumer.
interface bi_bus_driver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] bus_data;
    logic             bus_inv;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output bus_data,
        output bus_inv,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  bus_data,
        input  bus_inv,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/bi_bus_driver.sv
// Transmit-side bus-invert encoder with a one-deep output register.
// Each accepted word is sent either plain or inverted, whichever causes
// fewer transitions on the bus wires plus the invert line, measured
// against the word that is currently on the bus.
// Optional feature macro: BI_STATS_EN builds the raw/bus transition
// counters. Without it the counters read 0 and i_stats_clr is ignored.
module bi_bus_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    bi_bus_driver_if.slave   bus,
    input  logic             i_stats_clr,
    output logic [CNT_W-1:0] o_raw_toggles,
    output logic [CNT_W-1:0] o_bus_toggles
);
    // Wide enough for WIDTH + 1, the largest cost value.
    localparam int PW = $clog2(WIDTH + 1) + 1;

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    logic [WIDTH-1:0] r_bus_data;
    logic             r_bus_inv;
    logic             r_out_valid;

    logic             w_in_ready;
    logic             w_accept;
    logic [PW-1:0]    w_dist;
    logic [PW-1:0]    w_cost_plain;
    logic [PW-1:0]    w_cost_inv;
    logic             w_invert;
    logic [WIDTH-1:0] w_new_bus;

    // The slot is free when it is empty or when its word leaves this cycle.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Cost of each encoding relative to what is currently on the wires.
    // Plain wins ties; an even width never produces a tie anyway.
    always_comb begin
        w_dist       = popcount(bus.in_data ^ r_bus_data);
        w_cost_plain = w_dist + PW'(r_bus_inv);
        w_cost_inv   = PW'(WIDTH) - w_dist + PW'(!r_bus_inv);
        w_invert     = (w_cost_inv < w_cost_plain);
        w_new_bus    = w_invert ? ~bus.in_data : bus.in_data;
    end

    // Bus registers hold between words; only the occupancy bit drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_data  <= '0;
            r_bus_inv   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_bus_data  <= w_new_bus;
            r_bus_inv   <= w_invert;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready && r_out_valid) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.bus_data  = r_bus_data;
    assign bus.bus_inv   = r_bus_inv;
    assign bus.out_valid = r_out_valid;

`ifdef BI_STATS_EN
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SW-1:0] SAT = {{(SW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] r_prev_raw;
    logic [CNT_W-1:0] r_raw_toggles;
    logic [CNT_W-1:0] r_bus_toggles;

    logic [PW-1:0]    w_raw_inc;
    logic [PW-1:0]    w_bus_inc;
    logic [SW-1:0]    w_raw_sum;
    logic [SW-1:0]    w_bus_sum;
    logic [CNT_W-1:0] w_raw_next;
    logic [CNT_W-1:0] w_bus_next;

    // Transition counts for the accepted word and saturating sums.
    always_comb begin
        w_raw_inc  = popcount(bus.in_data ^ r_prev_raw);
        w_bus_inc  = popcount(w_new_bus ^ r_bus_data) + PW'(w_invert != r_bus_inv);
        w_raw_sum  = SW'(r_raw_toggles) + SW'(w_raw_inc);
        w_bus_sum  = SW'(r_bus_toggles) + SW'(w_bus_inc);
        w_raw_next = (w_raw_sum > SAT) ? {CNT_W{1'b1}} : w_raw_sum[CNT_W-1:0];
        w_bus_next = (w_bus_sum > SAT) ? {CNT_W{1'b1}} : w_bus_sum[CNT_W-1:0];
    end

    // Clear beats a same-cycle increment; prev_raw still tracks the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_raw    <= '0;
            r_raw_toggles <= '0;
            r_bus_toggles <= '0;
        end else begin
            if (w_accept) begin
                r_prev_raw <= bus.in_data;
            end
            if (i_stats_clr) begin
                r_raw_toggles <= '0;
                r_bus_toggles <= '0;
            end else if (w_accept) begin
                r_raw_toggles <= w_raw_next;
                r_bus_toggles <= w_bus_next;
            end
        end
    end

    assign o_raw_toggles = r_raw_toggles;
    assign o_bus_toggles = r_bus_toggles;
`else
    logic w_unused_stats_clr;

    assign w_unused_stats_clr = i_stats_clr;
    assign o_raw_toggles      = '0;
    assign o_bus_toggles      = '0;
`endif
endmodule
